utopia_rx_arbiter: RTL and testbench

ATM-layer receive controller that shares one downstream cell stream between four Level 1 Utopia Rx PHY ports. It polls each port's cell-available flag, grants ports round-robin, drives the per-port enable to pull one complete 53-byte cell, and checks start-of-cell framing. It forwards bytes tagged with the source port. It sits between the Utopia Rx pins and the ATM-layer cell buffer.

---
 rtl/utopia_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 54 +++++
 rtl/utopia_rx_arbiter.sv | 134 +++++++++++++
 tb/tb_utopia_rx_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/utopia_pkg.sv
// Shared types and constants for the Utopia Level 1 Rx arbiter slice.
//   CELL_BYTES_DEF : default ATM cell length in bytes
//   rx_arb_state_t : transfer FSM states
//   utopia_byte_t  : one Utopia data byte
package utopia_pkg;

    localparam int unsigned CELL_BYTES_DEF = 53;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN,
        GAP
    } rx_arb_state_t;

    typedef logic [7:0] utopia_byte_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among NPORTS requesters with a registered pointer.
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   req        : request vector
//   update     : advance the pointer past the current grant
//   gnt        : one-hot grant (combinational)
//   gnt_idx    : index of the grant (combinational)
//   valid      : at least one request present
module rr_arbiter #(
    parameter int unsigned NPORTS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NPORTS-1:0]         req,
    input  logic                      update,
    output logic [NPORTS-1:0]         gnt,
    output logic [$clog2(NPORTS)-1:0] gnt_idx,
    output logic                      valid
);

    localparam int unsigned IDXW = $clog2(NPORTS);

    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] cand;
    int unsigned     k;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        k       = 0;
        cand    = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            k    = (int'(ptr) + i) % NPORTS;
            cand = IDXW'(k);
            if (!valid && req[cand]) begin
                valid   = 1'b1;
                gnt_idx = cand;
            end
        end
        if (valid) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (update && valid) begin
            ptr <= (gnt_idx == IDXW'(NPORTS - 1)) ? '0 : gnt_idx + IDXW'(1);
        end
    end

endmodule

// File: rtl/utopia_rx_arbiter.sv
// ATM-layer receive controller: polls NPORTS Utopia Level 1 Rx PHYs,
// grants them round-robin, pulls one whole cell per grant, checks SOC
// framing and forwards port-tagged bytes.
//   clk, rst_n  : clock, asynchronous active-low reset
//   port_en     : per-port arbitration mask
//   rx_clav     : PHY cell-available flags
//   rx_en       : per-port read enable (at most one bit set)
//   rx_soc      : PHY start-of-cell flags
//   rx_data     : PHY data, port p in [8p+7:8p]
//   out_ready   : downstream can absorb the 2-byte in-flight window
//   out_valid, out_data, out_sop, out_eop, out_err, out_port : cell stream
//   soc_err_cnt : saturating count of aborted cells
module utopia_rx_arbiter
    import utopia_pkg::*;
#(
    parameter int unsigned NPORTS     = 4,
    parameter int unsigned CELL_BYTES = CELL_BYTES_DEF,
    parameter int unsigned ERRW       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NPORTS-1:0]         port_en,
    input  logic [NPORTS-1:0]         rx_clav,
    output logic [NPORTS-1:0]         rx_en,
    input  logic [NPORTS-1:0]         rx_soc,
    input  logic [8*NPORTS-1:0]       rx_data,
    input  logic                      out_ready,
    output logic                      out_valid,
    output utopia_byte_t              out_data,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic                      out_err,
    output logic [$clog2(NPORTS)-1:0] out_port,
    output logic [ERRW-1:0]           soc_err_cnt
);

    localparam int unsigned     IDXW     = $clog2(NPORTS);
    localparam int unsigned     CNTW     = $clog2(CELL_BYTES + 1);
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(CELL_BYTES - 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(CELL_BYTES);

    rx_arb_state_t     state, state_nxt;
    logic [NPORTS-1:0] req, arb_gnt, grant_oh;
    logic [IDXW-1:0]   arb_idx, grant_idx;
    logic              arb_valid, arb_update;
    logic [CNTW-1:0]   issued, captured;
    logic              issue, en_d1, capture, cap_soc, frame_err;
    utopia_byte_t      lane [NPORTS];
    utopia_byte_t      cap_data;

    for (genvar g = 0; g < NPORTS; g++) begin : g_lane
        assign lane[g] = rx_data[8*g +: 8];
    end

    assign req        = rx_clav & port_en;
    assign arb_update = (state == IDLE) && arb_valid;

    rr_arbiter #(.NPORTS(NPORTS)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .update  (arb_update),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .valid   (arb_valid)
    );

    assign issue = (state == XFER) && out_ready && (issued != FULL_CNT);
    assign rx_en = issue ? grant_oh : '0;

    // en_d1 marks the cycle the PHY is presenting a byte we asked for.
    // Bytes still in flight after an abort arrive in GAP and are dropped.
    assign capture   = en_d1 && ((state == XFER) || (state == DRAIN));
    assign cap_data  = lane[grant_idx];
    assign cap_soc   = rx_soc[grant_idx];
    assign frame_err = capture && (cap_soc != (captured == '0));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (arb_valid) state_nxt = XFER;
            XFER: begin
                if (frame_err)                            state_nxt = GAP;
                else if (issue && (issued == LAST_IDX))   state_nxt = DRAIN;
            end
            DRAIN: begin
                // captured reaches FULL_CNT in the cycle the last byte is on out_*
                if (frame_err || (captured == FULL_CNT))  state_nxt = GAP;
            end
            GAP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_oh    <= '0;
            grant_idx   <= '0;
            issued      <= '0;
            captured    <= '0;
            en_d1       <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_err     <= 1'b0;
            out_port    <= '0;
            soc_err_cnt <= '0;
        end else begin
            state <= state_nxt;
            en_d1 <= issue;
            if (arb_update) begin
                grant_oh  <= arb_gnt;
                grant_idx <= arb_idx;
                issued    <= '0;
                captured  <= '0;
            end else begin
                if (issue)   issued   <= issued + CNTW'(1);
                if (capture) captured <= captured + CNTW'(1);
            end
            out_valid <= capture;
            out_data  <= capture ? cap_data : '0;
            out_sop   <= capture && (captured == '0);
            out_eop   <= capture && ((captured == LAST_IDX) || frame_err);
            out_err   <= frame_err;
            out_port  <= capture ? grant_idx : '0;
            if (frame_err && (soc_err_cnt != '1)) begin
                soc_err_cnt <= soc_err_cnt + ERRW'(1);
            end
        end
    end

endmodule

// File: tb/tb_utopia_rx_arbiter.sv
`timescale 1ns/1ps
module tb_utopia_rx_arbiter;

    localparam int NP = 4;
    localparam int CB = 53;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     port_en;
    logic [NP-1:0]     rx_clav;
    logic [NP-1:0]     rx_en;
    logic [NP-1:0]     rx_soc;
    logic [8*NP-1:0]   rx_data;
    logic              out_ready;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_sop;
    logic              out_eop;
    logic              out_err;
    logic [1:0]        out_port;
    logic [15:0]       soc_err_cnt;

    utopia_rx_arbiter #(.NPORTS(NP), .CELL_BYTES(CB), .ERRW(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .port_en     (port_en),
        .rx_clav     (rx_clav),
        .rx_en       (rx_en),
        .rx_soc      (rx_soc),
        .rx_data     (rx_data),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_err     (out_err),
        .out_port    (out_port),
        .soc_err_cnt (soc_err_cnt)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [12:0] exp_q[$];     // {port, sop, eop, err, data}
    int          grant_q[$];
    int          phy_idx[NP];
    int          bad_pos[NP];
    bit          aborted[NP];
    int          en_hi[NP];
    int          first_en_cyc  = -1;
    int          first_val_cyc = -1;
    int          eop_cnt  = 0;
    int          cell_len = 0;
    int          last_len = 0;
    int          pause_valid = 0;
    bit          paused = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // PHY model: a byte requested in cycle t appears in cycle t+1.
    task automatic present(input int p);
        int   b   = phy_idx[p];
        logic bad = (b == bad_pos[p]);
        rx_data[8*p +: 8] = 8'(b);
        rx_soc[p] = (b == 0) ^ bad;
        if (!aborted[p]) begin
            exp_q.push_back({2'(p), (b == 0), ((b == CB-1) || bad), bad, 8'(b)});
            if (bad) aborted[p] = 1'b1;
        end
        phy_idx[p] = (b == CB-1) ? 0 : b + 1;
    endtask

    task automatic phy_clear(input int p);
        phy_idx[p] = 0;
        aborted[p] = 1'b0;
        bad_pos[p] = -1;
    endtask

    task automatic wait_cells(input int n, input string tag);
        int target = eop_cnt + n;
        for (int i = 0; i < 200*n && eop_cnt < target; i++) @(posedge clk);
        check(tag, eop_cnt, target);
        #1;
    endtask

    task automatic check_grants(input string tag, input int n, input logic [31:0] order);
        int g;
        for (int i = 0; i < n; i++) begin
            g = (grant_q.size() > 0) ? grant_q.pop_front() : -1;
            check(tag, g, {28'd0, order[4*i +: 4]});
        end
    endtask

    task automatic idle_gap();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        logic [NP-1:0] en_s;
        rx_soc  = '0;
        rx_data = '0;
        forever begin
            @(negedge clk);
            en_s = rx_en;
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (en_s[p]) present(p);
                else         rx_soc[p] = 1'b0;
            end
        end
    end

    initial begin
        logic [12:0] e;
        forever begin
            @(negedge clk);
            if (rx_en != '0) begin
                check("rx_en_onehot", $countones(rx_en), 1);
                if (first_en_cyc < 0) first_en_cyc = cyc;
                for (int p = 0; p < NP; p++) if (rx_en[p]) en_hi[p]++;
            end
            if (out_valid) begin
                if (first_val_cyc < 0) first_val_cyc = cyc;
                if (paused) pause_valid++;
                if (out_sop) begin
                    grant_q.push_back(int'(out_port));
                    cell_len = 0;
                end
                cell_len++;
                if (exp_q.size() == 0) begin
                    check("sb_underflow", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", {out_port, out_sop, out_eop, out_err, out_data}, e);
                end
                if (out_eop) begin
                    last_len = cell_len;
                    eop_cnt++;
                end
            end
        end
    end

    initial begin
        int ok;
        rst_n     = 1'b0;
        port_en   = '1;
        rx_clav   = '0;
        out_ready = 1'b1;
        for (int p = 0; p < NP; p++) begin
            phy_clear(p);
            en_hi[p] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", {rx_en, out_valid, out_data, out_sop, out_eop, out_err, out_port}, 0);
        check("reset_cnt", soc_err_cnt, 0);
        rst_n = 1'b1;
        idle_gap();

        // Round robin from pointer 0: 0,1,2,3 then back to 0.
        rx_clav = '1;
        wait_cells(5, "rr_timeout");
        rx_clav = '0;
        check_grants("rr_grant", 5, 32'h0_3210);
        check("rr_len", last_len, CB);
        idle_gap();

        // Single cell on port 1: latency, enable count, markers.
        for (int p = 0; p < NP; p++) en_hi[p] = 0;
        first_en_cyc  = -1;
        first_val_cyc = -1;
        rx_clav = 4'b0010;
        wait_cells(1, "single_timeout");
        rx_clav = '0;
        check("single_en_cnt", en_hi[1], CB);
        check("single_latency", first_val_cyc - first_en_cyc, 2);
        check("single_len", last_len, CB);
        check_grants("single_grant", 1, 32'h1);
        check("single_errcnt", soc_err_cnt, 0);
        idle_gap();

        // All ports requesting with the pointer at 2.
        rx_clav = '1;
        wait_cells(4, "rr2_timeout");
        rx_clav = '0;
        check_grants("rr2_grant", 4, 32'h1032);
        idle_gap();

        // Backpressure on port 2 after byte 20 has been requested.
        for (int p = 0; p < NP; p++) en_hi[p] = 0;
        rx_clav = 4'b0100;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            if (en_hi[2] >= 21) ok = 1;
        end
        check("bp_reach_b20", ok, 1);
        #1;
        out_ready   = 1'b0;
        paused      = 1'b1;
        pause_valid = 0;
        repeat (5) begin
            @(negedge clk);
            check("bp_rx_en", rx_en, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        paused    = 1'b0;
        check("bp_inflight", pause_valid, 2);
        wait_cells(1, "bp_timeout");
        rx_clav = '0;
        check("bp_len", last_len, CB);
        check("bp_en_cnt", en_hi[2], CB);
        check_grants("bp_grant", 1, 32'h2);
        idle_gap();

        // Bad SOC on byte 0 of port 3; port 2 follows.
        bad_pos[3] = 0;
        rx_clav = 4'b1100;
        wait_cells(1, "bad0_timeout");
        rx_clav = 4'b0100;
        check("bad0_len", last_len, 1);
        check("bad0_errcnt", soc_err_cnt, 1);
        wait_cells(1, "bad0_next_timeout");
        rx_clav = '0;
        check_grants("bad0_grant", 2, 32'h23);
        check("bad0_len_next", last_len, CB);
        phy_clear(3);
        idle_gap();

        // Unexpected SOC on byte 30 of port 0.
        bad_pos[0] = 30;
        rx_clav = 4'b0001;
        wait_cells(1, "bad30_timeout");
        rx_clav = '0;
        check("bad30_len", last_len, 31);
        check("bad30_errcnt", soc_err_cnt, 2);
        check_grants("bad30_grant", 1, 32'h0);
        idle_gap();
        phy_clear(0);
        check("bad30_sb_empty", exp_q.size(), 0);

        // Mask out port 1; drop port 0 from the mask mid-cell.
        for (int p = 0; p < NP; p++) en_hi[p] = 0;
        port_en = 4'b1101;
        rx_clav = '1;
        wait_cells(2, "mask_timeout");
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            if (en_hi[0] >= 10) ok = 1;
        end
        check("mask_p0_started", ok, 1);
        #1;
        port_en = 4'b1100;
        wait_cells(1, "mask_p0_timeout");
        rx_clav = '0;
        check("mask_p0_len", last_len, CB);
        check("mask_p1_en", en_hi[1], 0);
        check_grants("mask_grant", 3, 32'h032);
        port_en = '1;
        idle_gap();

        // Reset in the middle of a cell on port 0.
        rx_clav = 4'b0001;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            #2;
            if (phy_idx[0] >= 10) ok = 1;
        end
        check("rst_reach_b10", ok, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out", {rx_en, out_valid, out_data, out_sop, out_eop, out_err, out_port}, 0);
        check("rst_mid_cnt", soc_err_cnt, 0);
        exp_q.delete();
        grant_q.delete();
        for (int p = 0; p < NP; p++) phy_clear(p);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_cells(1, "rst_timeout");
        rx_clav = '0;
        check("rst_len", last_len, CB);
        check_grants("rst_grant", 1, 32'h0);
        idle_gap();

        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
